// File: rtl/serial_mouse_tx_emu_if.sv
// serial_mouse_tx_emu_if: host mouse inputs, RTS handshake and serial line of the mouse emulator.
interface serial_mouse_tx_emu_if;
  logic [7:0] mouse_dx;
  logic [7:0] mouse_dy;
  logic [1:0] mouse_btn;
  logic mouse_upd;
  logic serial_mouse_rts;
  logic serial_mouse_tx;
  logic busy;
  modport master(output mouse_dx, mouse_dy, mouse_btn, mouse_upd, serial_mouse_rts, input serial_mouse_tx, busy);
  modport slave(input mouse_dx, mouse_dy, mouse_btn, mouse_upd, serial_mouse_rts, output serial_mouse_tx, busy);
endinterface

// File: rtl/serial_mouse_tx_emu.sv
// serial_mouse_tx_emu: Microsoft serial mouse emulator, 7N1 packets plus 'M' ident on RTS rise.
module serial_mouse_tx_emu #(
  parameter int BAUD_DIV = 23863,
  parameter int ID_GAP_BITS = 2
) (
  input logic clk_vga,
  input logic reset_wire,
  serial_mouse_tx_emu_if.slave bus
);
  typedef enum logic [2:0] {OFF, GAP, ID, IDLE, B1, B2, B3} state_t;
  localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  localparam int BW = ID_GAP_BITS > 9 ? $clog2(ID_GAP_BITS) : 4;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [2:0] rts_q, vld;
  logic [7:0] acc_x, acc_y, base_x, base_y, px, py;
  logic [1:0] last_btn, pb;
  logic [6:0] cur;
  logic [8:0] frame;
  logic rts_s, rise, bit_end, frame_end, trig, take, clr;
  function automatic logic [7:0] sat(input logic [8:0] s);
    return s[8] == s[7] ? s[7:0] : {s[8], {7{~s[8]}}};
  endfunction
  assign rts_s = rts_q[1];
  // vld keeps the reset-cleared synchronizer from faking a rising edge when RTS is already high
  assign rise = rts_q[1] & ~rts_q[2] & vld[2];
  assign bit_end = cnt == CW'(BAUD_DIV - 1);
  assign frame_end = bit_end && bit_idx == BW'(8);
  assign trig = acc_x != 8'd0 || acc_y != 8'd0 || bus.mouse_btn != last_btn;
  assign take = state == IDLE && trig && rts_s;
  assign clr = !rts_s || take;
  assign base_x = clr ? 8'd0 : acc_x;
  assign base_y = clr ? 8'd0 : acc_y;
  always_comb begin
    state_n = state;
    cnt_n = bit_end ? '0 : cnt + CW'(1);
    bit_n = bit_idx + BW'(bit_end);
    case (state)
      OFF: if (rise) state_n = GAP;
      GAP: if (bit_end && bit_idx == BW'(ID_GAP_BITS - 1)) state_n = ID;
      ID: if (frame_end) state_n = IDLE;
      IDLE: if (trig) state_n = B1;
      B1: if (frame_end) state_n = B2;
      B2: if (frame_end) state_n = B3;
      B3: if (frame_end) state_n = IDLE;
      default: state_n = OFF;
    endcase
    if (!rts_s) state_n = OFF;
    if (state_n != state || state == OFF || state == IDLE) begin
      cnt_n = '0;
      bit_n = '0;
    end
  end
  always_ff @(posedge clk_vga or posedge reset_wire)
    if (reset_wire) begin
      state <= OFF;
      cnt <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
    end
  always_ff @(posedge clk_vga or posedge reset_wire)
    if (reset_wire) begin
      rts_q <= '0;
      vld <= '0;
      acc_x <= '0;
      acc_y <= '0;
      last_btn <= '0;
      px <= '0;
      py <= '0;
      pb <= '0;
    end else begin
      rts_q <= {rts_q[1:0], bus.serial_mouse_rts};
      vld <= {vld[1:0], 1'b1};
      acc_x <= !rts_s ? 8'd0 : bus.mouse_upd ? sat({base_x[7], base_x} + {bus.mouse_dx[7], bus.mouse_dx}) : base_x;
      acc_y <= !rts_s ? 8'd0 : bus.mouse_upd ? sat({base_y[7], base_y} + {bus.mouse_dy[7], bus.mouse_dy}) : base_y;
      if (clr) last_btn <= bus.mouse_btn;
      if (take) begin
        px <= acc_x;
        py <= acc_y;
        pb <= bus.mouse_btn;
      end
    end
  assign cur = state == ID ? 7'h4D :
               state == B1 ? {1'b1, pb[0], pb[1], py[7:6], px[7:6]} :
               state == B2 ? {1'b0, px[5:0]} : {1'b0, py[5:0]};
  assign frame = {1'b1, cur, 1'b0};
  assign bus.serial_mouse_tx = state inside {ID, B1, B2, B3} ? frame[bit_idx[3:0]] : 1'b1;
  assign bus.busy = !(state inside {OFF, IDLE});
endmodule
